// File: rtl/merge5.sv
// Two-input round-robin flit merge into a 2-entry output buffer.
// Each buffered flit carries the index of the port it arrived on.
module merge5 #(
    parameter int W     = 9,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  in0_data,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [W-1:0]  in1_data,
    input  logic          in1_valid,
    output logic          in1_ready,
    output logic [W-1:0]  out_data,
    output logic          out_sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] gnt_cnt0,
    output logic [CW-1:0] gnt_cnt1
);

    logic [W:0] mem [DEPTH];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       rr_ptr;

    logic       space;
    logic       gnt0;
    logic       gnt1;
    logic       push;
    logic       pop;
    logic [W:0] push_entry;

    // Space is taken from the registered count only, so a pop never frees a slot in the same cycle.
    assign space = (count < 2'(DEPTH));

    assign gnt0 = in0_valid & (~in1_valid | ~rr_ptr);
    assign gnt1 = in1_valid & (~in0_valid |  rr_ptr);

    // Gating with rst_n holds both readies low while reset is asserted.
    assign in0_ready = gnt0 & space & rst_n;
    assign in1_ready = gnt1 & space & rst_n;

    assign push       = in0_ready | in1_ready;
    assign push_entry = in1_ready ? {1'b1, in1_data} : {1'b0, in0_data};

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr][W-1:0];
    assign out_sel   = mem[rd_ptr][W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= 1'b0;
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (in0_ready) begin
                rr_ptr   <= 1'b1;
                gnt_cnt0 <= gnt_cnt0 + CW'(1);
            end else if (in1_ready) begin
                rr_ptr   <= 1'b0;
                gnt_cnt1 <= gnt_cnt1 + CW'(1);
            end
        end
    end

endmodule

// File: doc/merge5.md
# merge5

Two-input flit merge for the NoC: the return direction of the 1-to-2 address decoder. Flits arriving on two ingress channels are arbitrated round-robin into one egress channel through a 2-entry output buffer. Each egress flit carries a sideband bit naming its source port, the counterpart of the decoder's select output. It sits at every tree node on the upward path, recombining the two child branches toward the parent.

## Interface
- W, default 9: flit width; bits [W-1:W-4] are the 4-bit address, passed through untouched.
- DEPTH, fixed 2: output buffer entries. Not to be overridden.
- CW, default 16: width of the per-port grant counters.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in0_data  in  W  flit from child 0.
- in0_valid  in  1  in0_data is valid.
- in0_ready  out  1  in0 flit is accepted this cycle.
- in1_data, in1_valid, in1_ready: same as in0, for child 1.
- out_data  out  W  head flit of the buffer.
- out_sel  out  1  source port of out_data: 0 = in0, 1 = in1.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  downstream accepts out_data/out_sel.
- gnt_cnt0, gnt_cnt1  out  CW  count of flits accepted from each port.

## Operation
- Handshakes are valid/ready. A transfer occurs on a rising edge where valid and ready are both 1.
- Valid must hold, and its data stay stable, until the transfer. Ready may be dropped at any time.
- Buffer: a 2-entry FIFO of {sel, data}, with count 0..2.
  - `space` = (count < 2), evaluated on registered count only. No same-cycle pass-through when full.
- Arbitration (combinational), with rr_ptr as the priority port:
  - Only one input valid: grant it.
  - Both valid: grant rr_ptr.
  - inX_ready = grantX & space. At most one ready is high per cycle.
  - Ready never depends on out_ready.
- On an accepted flit from port X:
  - push {X, inX_data};
  - rr_ptr <= ~X, so the next tie goes to the other port;
  - gnt_cntX += 1, wrapping modulo 2^CW.
- rr_ptr does not change when nothing is accepted.
- Pop when out_valid & out_ready.
  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
- out_data and out_sel come from the registered buffer head. No combinational path from any input to any output except inX_ready.
- Data bits are never modified. The address field is not inspected.

## Timing
- Reset (async assert, sync release): count=0 and rr_ptr=0. All outputs 0: out_valid, out_data, out_sel, gnt_cnt0/1, in0_ready, in1_ready.
- First cycle after reset release: inX_ready may rise as soon as inX_valid is 1.
- Latency: a flit accepted at edge N is on out_data with out_valid=1 from just after edge N, when the buffer was empty.
- Throughput: 1 flit/cycle sustained while out_ready=1; count stays ≤1.
- Downstream stall (out_ready=0): at most 2 flits accepted, then both readies go 0 until a pop.
  - After a pop from count=2, acceptance resumes on the following edge, not the same one.
- Reset asserted mid-operation: buffer contents discarded, counters cleared, outputs drop to reset values immediately. No flit is emitted twice after release.
- Counter wrap: 2^CW-1 + 1 -> 0, with no flag.

## Test plan
- Reset/idle: hold rst_n=0 with both inputs valid -> all outputs 0. Release -> in0_valid=1, data 9'h1A5, out_ready=1 -> out_data=9'h1A5 and out_sel=0 one edge later, gnt_cnt0=1.
- Fairness: both inputs valid continuously (in0 = 9'h100..., in1 = 9'h0F0...), out_ready=1 -> out_sel strictly alternates 0,1,0,1 starting with 0. After 100 flits, gnt_cnt0 = gnt_cnt1 = 50.
- Backpressure: out_ready=0 with both valid -> exactly 2 flits accepted, then in0_ready = in1_ready = 0. Raise out_ready for 1 cycle -> 1 pop; next edge 1 more accept. Order and sel intact.
- Single-port priority: only in1 valid for 3 flits -> out_sel=1 ×3, rr_ptr=0. Then both valid -> in0 wins first.
- Async reset mid-stream: assert rst_n=0 between edges with count=2 -> out_valid falls immediately without a clock edge. After release, only newly sent flits appear.
- Counter wrap (CW=4 override): 17 flits from in0 -> gnt_cnt0=1, gnt_cnt1=0.
